wb_stage_buf: RTL

Parametrised write-back stage for the 5-stage MIPS pipeline, sitting between the MEM stage and the register file. It replaces the single-register write-back stage with a DEPTH-entry in-order retire buffer, so MEM is not stalled when the register-file write port is shared and not granted. It also adds load-data alignment and sign/zero extension at enqueue, and forwarding lookup across all pending entries for two ID-stage read ports.

---
 rtl/wb_stage_buf.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_stage_buf.sv
// Write-back stage as a DEPTH-entry in-order retire buffer between MEM and the register file.
// Load data is aligned and extended at enqueue; pending entries forward to two ID read ports.
module wb_stage_buf #(
   parameter int DATA_W = 32,
   parameter int RF_AW  = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              mem_to_wb_valid,
   output logic              wb_allow_in,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_mem_rdata,
   input  logic [1:0]        in_addr_lo,
   input  logic [2:0]        in_ld_op,
   input  logic [1:0]        in_wb_sel,
   input  logic              in_rf_we,
   input  logic [RF_AW-1:0]  in_rf_waddr,
   input  logic              rf_ready,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [RF_AW-1:0]  id_raddr0,
   input  logic [RF_AW-1:0]  id_raddr1,
   output logic              fwd_hit0,
   output logic              fwd_hit1,
   output logic [DATA_W-1:0] fwd_data0,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [4:0]        debug_wb_rf_wnum,
   output logic [31:0]       debug_wb_rf_wdata
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0]     head, tail;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] pc_p1    [DEPTH];
   logic [DATA_W-1:0] wdata_p1 [DEPTH];
   logic [RF_AW-1:0]  waddr_p1 [DEPTH];
   logic              we_p1    [DEPTH];

   logic              nonempty, push, pop;
   logic [DATA_W-1:0] push_wdata_p0;
   logic              push_we_p0;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        lo,
                                                  input logic [2:0]        op);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (op)
         3'b001:  load_ext = {{(DATA_W-8){b[7]}}, b};
         3'b010:  load_ext = {{(DATA_W-8){1'b0}}, b};
         3'b011:  load_ext = {{(DATA_W-16){h[15]}}, h};
         3'b100:  load_ext = {{(DATA_W-16){1'b0}}, h};
         default: load_ext = w;
      endcase
   endfunction

   // Stage p0: final write data is resolved before the entry is stored
   always_comb begin
      push_wdata_p0 = '0;
      case (in_wb_sel)
         2'b00:   push_wdata_p0 = in_alu_res;
         2'b01:   push_wdata_p0 = load_ext(in_mem_rdata, in_addr_lo, in_ld_op);
         2'b10:   push_wdata_p0 = in_pc + DATA_W'(8);
         default: push_wdata_p0 = '0;
      endcase
   end

   assign push_we_p0  = in_rf_we & (in_wb_sel != 2'b11);
   assign nonempty    = (count != '0);
   assign wb_allow_in = (count < CW'(DEPTH)) | (nonempty & rf_ready);
   assign push        = mem_to_wb_valid & wb_allow_in & ~flush;
   assign pop         = nonempty & rf_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Stage p1: entry storage, qualified by count so it needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         pc_p1[tail]    <= in_pc;
         wdata_p1[tail] <= push_wdata_p0;
         waddr_p1[tail] <= in_rf_waddr;
         we_p1[tail]    <= push_we_p0;
      end
   end

   assign rf_we             = nonempty & we_p1[head];
   assign rf_waddr          = nonempty ? waddr_p1[head] : '0;
   assign rf_wdata          = nonempty ? wdata_p1[head] : '0;
   assign debug_wb_pc       = nonempty ? pc_p1[head] : '0;
   assign debug_wb_rf_wen   = {4{rf_we & rf_ready}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   // Walk oldest to youngest so the youngest matching entry overwrites earlier hits
   always_comb begin
      logic [PW-1:0] idx;
      idx       = '0;
      fwd_hit0  = 1'b0;
      fwd_hit1  = 1'b0;
      fwd_data0 = '0;
      fwd_data1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = PW'((int'(head) + i) % DEPTH);
         if ((CW'(i) < count) && we_p1[idx]) begin
            if ((waddr_p1[idx] == id_raddr0) && (id_raddr0 != '0)) begin
               fwd_hit0  = 1'b1;
               fwd_data0 = wdata_p1[idx];
            end
            if ((waddr_p1[idx] == id_raddr1) && (id_raddr1 != '0)) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = wdata_p1[idx];
            end
         end
      end
   end

endmodule
